timer_cnt_ctrl: RTL and testbench

Counter controller for the timer IP: owns the 64-bit free-running count and sequences it using the control outputs of the timer register block. Those controls are enable, divider enable/value, halt request, counter-reset pulse and TDR0/TDR1 write strobes with merged data. It returns `count` to the register block, which uses it for TDR readback and compare/interrupt. It contains a run/idle/halt state machine and a programmable power-of-two prescaler.

---
 rtl/timer_pkg.sv | 28 ++
 rtl/timer_prescaler.sv | 57 +++++
 rtl/timer_cnt_ctrl.sv | 113 +++++++++++
 tb/tb_timer_cnt_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the timer IP: counter FSM states,
// prescaler width, register map offsets and TDR reset defaults.
package timer_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } cnt_state_t;

  // Largest legal div_val; also the prescaler width in bits.
  localparam int MAX_DIV = 8;

  // Register map offsets.
  localparam logic [11:0] ADDR_TCR   = 12'h000;
  localparam logic [11:0] ADDR_TDR0  = 12'h004;
  localparam logic [11:0] ADDR_TDR1  = 12'h008;
  localparam logic [11:0] ADDR_TCMP0 = 12'h00C;
  localparam logic [11:0] ADDR_TCMP1 = 12'h010;
  localparam logic [11:0] ADDR_TIER  = 12'h014;
  localparam logic [11:0] ADDR_TISR  = 12'h018;
  localparam logic [11:0] ADDR_THCSR = 12'h01C;

  // Counter reset value, split into halves.
  localparam logic [31:0] DEFAULT_TDR0 = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TDR1 = 32'h0000_0000;

endpackage

// File: rtl/timer_prescaler.sv
// Power-of-two prescaler. Counts while run is high and raises tick when
// the count reaches the limit (2^div_val - 1, or 0 when div_en is low).
// Holds while run is low; clr zeroes it. A divider change while running
// also zeroes it so a stale phase never meets a new limit.
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int MAX_DIV = timer_pkg::MAX_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       clr,
  input  logic       div_en,
  input  logic [3:0] div_val,
  output logic       tick
);

  localparam logic [MAX_DIV-1:0] ONE = MAX_DIV'(1);

  logic [MAX_DIV-1:0] cnt_q, cnt_d;
  logic [MAX_DIV-1:0] limit;
  logic [MAX_DIV:0]   pow2;
  logic               div_en_q, div_en_d;
  logic [3:0]         div_val_q, div_val_d;
  logic               div_chg;

  // Limit decode, tick compare and next prescaler value.
  always_comb begin
    pow2      = (MAX_DIV+1)'(1) << div_val;
    limit     = div_en ? (pow2[MAX_DIV-1:0] - ONE) : '0;
    div_chg   = run & ((div_en != div_en_q) | (div_val != div_val_q));
    tick      = run & (cnt_q == limit);
    div_en_d  = div_en;
    div_val_d = div_val;
    cnt_d     = cnt_q;
    if (clr | div_chg) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = tick ? '0 : cnt_q + ONE;
    end
  end

  // Prescaler count and last-seen divider settings.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      div_en_q  <= 1'b0;
      div_val_q <= 4'd0;
    end else begin
      cnt_q     <= cnt_d;
      div_en_q  <= div_en_d;
      div_val_q <= div_val_d;
    end
  end

endmodule

// File: rtl/timer_cnt_ctrl.sv
// Timer counter controller: IDLE/RUN/HALT sequencing of a 64-bit counter
// with prescaled ticks, TDR half-writes and a counter-reset pulse.
// Count update priority: rst_cnt, then TDR write, then tick, then hold.
module timer_cnt_ctrl
  import timer_pkg::*;
#(
  parameter int CNT_W   = 64,
  parameter int MAX_DIV = timer_pkg::MAX_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             timer_en,
  input  logic             div_en,
  input  logic [3:0]       div_val,
  input  logic             halt_req,
  input  logic             dbg_mode,
  input  logic             rst_cnt,
  input  logic             tdr0_wr,
  input  logic             tdr1_wr,
  input  logic [31:0]      mem_tdr0,
  input  logic [31:0]      mem_tdr1,
  output logic [CNT_W-1:0] count,
  output logic             cnt_tick,
  output logic             cnt_wrap,
  output logic             halted
);

  cnt_state_t       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             cnt_tick_q, cnt_tick_d;
  logic             cnt_wrap_q, cnt_wrap_d;
  logic             halted_q, halted_d;
  logic             run_s, idle_s, halt_hit, tdr_wr;
  logic             presc_clr, presc_tick;

  assign halt_hit  = halt_req & dbg_mode;
  assign tdr_wr    = tdr0_wr | tdr1_wr;
  assign presc_clr = rst_cnt | tdr_wr | idle_s;

  timer_prescaler #(.MAX_DIV(MAX_DIV)) u_presc (
    .clk     (clk),
    .rst     (rst),
    .run     (run_s),
    .clr     (presc_clr),
    .div_en  (div_en),
    .div_val (div_val),
    .tick    (presc_tick)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state; timer_en low wins over a halt request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (timer_en) state_d = S_RUN;
      S_RUN:   if (!timer_en) state_d = S_IDLE;
               else if (halt_hit) state_d = S_HALT;
      S_HALT:  if (!timer_en) state_d = S_IDLE;
               else if (!halt_hit) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: prescaler run/clear qualifiers and next halted flag.
  always_comb begin
    run_s    = (state_q == S_RUN);
    idle_s   = (state_q == S_IDLE);
    halted_d = (state_d == S_HALT);
  end

  // Next count with tick and wrap flags for the cycle it lands.
  always_comb begin
    count_d    = count_q;
    cnt_tick_d = 1'b0;
    cnt_wrap_d = 1'b0;
    if (rst_cnt) begin
      count_d = '0;
    end else if (tdr_wr) begin
      if (tdr0_wr) count_d[31:0]       = mem_tdr0;
      if (tdr1_wr) count_d[CNT_W-1:32] = mem_tdr1;
    end else if (presc_tick) begin
      count_d    = count_q + CNT_W'(1);
      cnt_tick_d = 1'b1;
      cnt_wrap_d = &count_q;
    end
  end

  // Counter and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= {DEFAULT_TDR1, DEFAULT_TDR0};
      cnt_tick_q <= 1'b0;
      cnt_wrap_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      count_q    <= count_d;
      cnt_tick_q <= cnt_tick_d;
      cnt_wrap_q <= cnt_wrap_d;
      halted_q   <= halted_d;
    end
  end

  assign count    = count_q;
  assign cnt_tick = cnt_tick_q;
  assign cnt_wrap = cnt_wrap_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_timer_cnt_ctrl.sv
// Directed bench for timer_cnt_ctrl. Inputs are driven and outputs sampled
// 1ns after each rising edge; "edge k" below means the k-th edge after
// the stimulus for a scenario was applied.
module tb_timer_cnt_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        timer_en, div_en, halt_req, dbg_mode, rst_cnt;
  logic [3:0]  div_val;
  logic        tdr0_wr, tdr1_wr;
  logic [31:0] mem_tdr0, mem_tdr1;
  logic [63:0] count;
  logic        cnt_tick, cnt_wrap, halted;

  int n_tests = 0;
  int n_fail  = 0;

  timer_cnt_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .timer_en (timer_en),
    .div_en   (div_en),
    .div_val  (div_val),
    .halt_req (halt_req),
    .dbg_mode (dbg_mode),
    .rst_cnt  (rst_cnt),
    .tdr0_wr  (tdr0_wr),
    .tdr1_wr  (tdr1_wr),
    .mem_tdr0 (mem_tdr0),
    .mem_tdr1 (mem_tdr1),
    .count    (count),
    .cnt_tick (cnt_tick),
    .cnt_wrap (cnt_wrap),
    .halted   (halted)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] exp_cnt;
    logic        exp_tick;

    // Reset block.
    rst = 1'b1; timer_en = 0; div_en = 0; div_val = 0; halt_req = 0;
    dbg_mode = 0; rst_cnt = 0; tdr0_wr = 0; tdr1_wr = 0;
    mem_tdr0 = '0; mem_tdr1 = '0;
    step(2);
    chk("rst_count", count, 64'd0);
    chk("rst_tick", {63'd0, cnt_tick}, 64'd0);
    chk("rst_wrap", {63'd0, cnt_wrap}, 64'd0);
    chk("rst_halted", {63'd0, halted}, 64'd0);
    rst = 1'b0;

    // Undivided run: RUN from edge 1, first increment at edge 2.
    timer_en = 1;
    step(1);
    chk("run_e1_count", count, 64'd0);
    chk("run_e1_tick", {63'd0, cnt_tick}, 64'd0);
    for (int k = 2; k <= 10; k++) begin
      step(1);
      chk("run_count", count, 64'(k - 1));
      chk("run_tick", {63'd0, cnt_tick}, 64'd1);
    end

    // Disable: the tick decided in the last RUN cycle lands, then hold.
    timer_en = 0;
    step(3);
    chk("idle_hold_count", count, 64'd10);
    chk("idle_hold_tick", {63'd0, cnt_tick}, 64'd0);
    rst_cnt = 1;
    step(1);
    rst_cnt = 0;
    chk("rst_cnt_idle", count, 64'd0);

    // Divide by 8: ticks land at edges 9, 17, 25, 33, 41.
    div_en = 1; div_val = 4'd3; timer_en = 1;
    exp_cnt = 0;
    for (int k = 1; k <= 41; k++) begin
      step(1);
      exp_tick = (k >= 9) && (((k - 9) % 8) == 0);
      if (exp_tick) exp_cnt++;
      chk("div8_tick", {63'd0, cnt_tick}, {63'd0, exp_tick});
    end
    chk("div8_count", count, 64'd5);

    // Full 64-bit load in IDLE, then wrap through all-ones.
    timer_en = 0;
    step(1);
    tdr0_wr = 1; tdr1_wr = 1; mem_tdr0 = 32'hFFFF_FFFE; mem_tdr1 = 32'hFFFF_FFFF;
    step(1);
    tdr0_wr = 0; tdr1_wr = 0;
    chk("load_count", count, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("load_tick", {63'd0, cnt_tick}, 64'd0);
    div_en = 0; timer_en = 1;
    step(1);
    chk("wrap_e1_count", count, 64'hFFFF_FFFF_FFFF_FFFE);
    step(1);
    chk("wrap_e2_count", count, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("wrap_e2_wrap", {63'd0, cnt_wrap}, 64'd0);
    step(1);
    chk("wrap_e3_count", count, 64'd0);
    chk("wrap_e3_wrap", {63'd0, cnt_wrap}, 64'd1);
    chk("wrap_e3_tick", {63'd0, cnt_tick}, 64'd1);
    step(1);
    chk("wrap_e4_count", count, 64'd1);
    chk("wrap_e4_wrap", {63'd0, cnt_wrap}, 64'd0);

    // Half writes in RUN: other half holds, no tick on the write cycle.
    tdr1_wr = 1; mem_tdr1 = 32'hA5A5_0001; mem_tdr0 = 32'hDEAD_BEEF;
    step(1);
    tdr1_wr = 0;
    chk("tdr1_only", count, 64'hA5A5_0001_0000_0001);
    chk("tdr1_no_tick", {63'd0, cnt_tick}, 64'd0);
    tdr0_wr = 1; mem_tdr0 = 32'h1234_5678; mem_tdr1 = 32'hFFFF_0000;
    step(1);
    tdr0_wr = 0;
    chk("tdr0_only", count, 64'hA5A5_0001_1234_5678);
    chk("tdr0_no_tick", {63'd0, cnt_tick}, 64'd0);
    step(1);
    chk("after_wr_count", count, 64'hA5A5_0001_1234_5679);
    chk("after_wr_tick", {63'd0, cnt_tick}, 64'd1);

    // Clear and restart divide by 4: tick at edge 5, prescaler 1 after edge 6.
    timer_en = 0; rst_cnt = 1;
    step(1);
    rst_cnt = 0;
    chk("rst_cnt_priority", count, 64'd0);
    div_en = 1; div_val = 4'd2; timer_en = 1;
    step(6);
    chk("div4_first", count, 64'd1);

    // Halt for 20 cycles; prescaler frozen at 2.
    halt_req = 1; dbg_mode = 1;
    for (int k = 0; k < 20; k++) begin
      step(1);
      chk("halt_flag", {63'd0, halted}, 64'd1);
      chk("halt_count", count, 64'd1);
    end
    halt_req = 0; dbg_mode = 0;
    step(1);
    chk("resume_halted", {63'd0, halted}, 64'd0);
    chk("resume_e1_count", count, 64'd1);
    step(1);
    chk("resume_e2_count", count, 64'd1);
    step(1);
    chk("resume_phase_count", count, 64'd2);
    chk("resume_phase_tick", {63'd0, cnt_tick}, 64'd1);

    // halt_req without dbg_mode is ignored.
    halt_req = 1; dbg_mode = 0;
    for (int k = 0; k < 4; k++) begin
      step(1);
      chk("nohalt_flag", {63'd0, halted}, 64'd0);
    end
    chk("nohalt_count", count, 64'd3);
    halt_req = 0;

    // rst_cnt coincident with tdr1_wr and a tick.
    div_en = 0;
    step(2);
    rst_cnt = 1; tdr1_wr = 1; mem_tdr1 = 32'h0000_00FF;
    step(1);
    rst_cnt = 0; tdr1_wr = 0;
    chk("coinc_count", count, 64'd0);
    chk("coinc_tick", {63'd0, cnt_tick}, 64'd0);
    step(1);
    chk("coinc_next_count", count, 64'd1);
    chk("coinc_next_tick", {63'd0, cnt_tick}, 64'd1);

    // Halt on a tick cycle: the decided tick still lands, then freezes.
    halt_req = 1; dbg_mode = 1;
    step(1);
    chk("halt_tick_lands", count, 64'd2);
    chk("halt_tick_flag", {63'd0, halted}, 64'd1);
    step(1);
    chk("halt_frozen", count, 64'd2);
    chk("halt_frozen_tick", {63'd0, cnt_tick}, 64'd0);

    // Synchronous reset mid-count overrides a coincident TDR write.
    rst = 1; tdr0_wr = 1; mem_tdr0 = 32'h0000_0077;
    step(1);
    rst = 0; tdr0_wr = 0; halt_req = 0; dbg_mode = 0;
    chk("midrst_count", count, 64'd0);
    chk("midrst_tick", {63'd0, cnt_tick}, 64'd0);
    chk("midrst_wrap", {63'd0, cnt_wrap}, 64'd0);
    chk("midrst_halted", {63'd0, halted}, 64'd0);
    step(1);
    chk("post_rst_count", count, 64'd0);
    step(1);
    chk("post_rst_run", count, 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
